// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared ALU opcodes, operand selects and ID/EX register layout
package ex_pkg;

  localparam int EX_DATA_WIDTH     = 32;
  localparam int EX_OPCODE_LENGTH  = 4;
  localparam int EX_REG_ADDR_WIDTH = 5;

  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_ADD  = 4'b0000;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_SUB  = 4'b0001;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_XOR  = 4'b0010;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_OR   = 4'b0011;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_AND  = 4'b0100;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_SRL  = 4'b0101;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_SLL  = 4'b0110;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_SRA  = 4'b0111;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_SLT  = 4'b1000;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_SLTU = 4'b1001;
  localparam logic [EX_OPCODE_LENGTH-1:0] ALU_EQ   = 4'b1010;

  // Encoding 2'b11 is reserved and decodes like SRC_A_ZERO.
  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10
  } src_a_sel_t;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_sel_t;

  // All-zero contents are a bubble: invalid, no write, ADD, zero operands.
  typedef struct packed {
    logic                         valid;
    logic [EX_REG_ADDR_WIDTH-1:0] rs1;
    logic [EX_REG_ADDR_WIDTH-1:0] rs2;
    logic [EX_REG_ADDR_WIDTH-1:0] rd;
    logic [EX_DATA_WIDTH-1:0]     rs1_val;
    logic [EX_DATA_WIDTH-1:0]     rs2_val;
    logic [EX_DATA_WIDTH-1:0]     imm;
    logic [EX_DATA_WIDTH-1:0]     pc;
    logic [1:0]                   src_a_sel;
    logic                         src_b_sel;
    logic [EX_OPCODE_LENGTH-1:0]  operation;
    logic                         reg_write;
  } idex_t;

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// rtl/ex_operand_stage_forward_unit.sv - resolves one operand against EX/MEM and MEM/WB producers
module forward_unit
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH     = EX_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = EX_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]     reg_val,
  input  logic                      exm_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
  input  logic [DATA_WIDTH-1:0]     exm_result,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     fwd_val
);

  // The younger producer (EX/MEM) wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_val = reg_val;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs)) begin
      fwd_val = exm_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      fwd_val = wb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with forwarding, stall and flush, driving the ALU
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH     = EX_DATA_WIDTH,
  parameter int OPCODE_LENGTH  = EX_OPCODE_LENGTH,
  parameter int REG_ADDR_WIDTH = EX_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [1:0]                id_src_a_sel,
  input  logic                      id_src_b_sel,
  input  logic [OPCODE_LENGTH-1:0]  id_operation,
  input  logic                      id_reg_write,
  input  logic                      exm_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
  input  logic [DATA_WIDTH-1:0]     exm_result,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic                      ex_valid,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [DATA_WIDTH-1:0]     ex_store_data
);

  idex_t                 q;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs(q.rs1), .reg_val(q.rs1_val),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .fwd_val(fwd_a)
  );

  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs(q.rs2), .reg_val(q.rs2_val),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .fwd_val(fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '0;
    end else if (stall) begin
      // Re-capture resolved operands so a retiring producer's value is not lost.
      q.rs1_val <= fwd_a;
      q.rs2_val <= fwd_b;
    end else begin
      q.valid     <= id_valid;
      q.rs1       <= id_rs1;
      q.rs2       <= id_rs2;
      q.rd        <= id_rd;
      // The register file is written this same edge, so its read data is stale.
      q.rs1_val   <= (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_result : id_rs1_data;
      q.rs2_val   <= (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_result : id_rs2_data;
      q.imm       <= id_imm;
      q.pc        <= id_pc;
      q.src_a_sel <= id_src_a_sel;
      q.src_b_sel <= id_src_b_sel;
      q.operation <= id_operation;
      q.reg_write <= id_reg_write && id_valid;
    end
  end

  always_comb begin
    case (src_a_sel_t'(q.src_a_sel))
      SRC_A_RS1: SrcA = fwd_a;
      SRC_A_PC:  SrcA = q.pc;
      default:   SrcA = '0;
    endcase
    SrcB = (src_b_sel_t'(q.src_b_sel) == SRC_B_IMM) ? q.imm : fwd_b;
  end

  assign ex_valid      = q.valid;
  assign ex_rd         = q.rd;
  assign ex_reg_write  = q.reg_write;
  assign ex_pc         = q.pc;
  assign Operation     = q.operation;
  assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed and random checks of ex_operand_stage against a behavioural model
module tb_ex_operand_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [1:0]  id_src_a_sel;
  logic        id_src_b_sel;
  logic [3:0]  id_operation;
  logic        id_reg_write;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_result;
  logic        ex_valid, ex_reg_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;

  int nvec = 0;
  int nmis = 0;

  // Model of the instruction currently held in EX
  logic        m_valid, m_we, m_bsel;
  logic [1:0]  m_asel;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_a, m_b, m_imm, m_pc;
  logic [3:0]  m_op;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel), .id_operation(id_operation),
    .id_reg_write(id_reg_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] v);
    if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs) return exm_result;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return wb_result;
    return v;
  endfunction

  function automatic logic [31:0] wb_bypass(input logic [4:0] rs, input logic [31:0] v);
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return wb_result;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ea, eb;
    #1;
    ea = (m_asel == 2'b00) ? resolve(m_rs1, m_a) : (m_asel == 2'b01) ? m_pc : 32'd0;
    eb = m_bsel ? m_imm : resolve(m_rs2, m_b);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
    chk({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, m_we});
    chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, m_rd});
    chk({tag, ".ex_pc"}, ex_pc, m_pc);
    chk({tag, ".Operation"}, {28'd0, Operation}, {28'd0, m_op});
    chk({tag, ".SrcA"}, SrcA, ea);
    chk({tag, ".SrcB"}, SrcB, eb);
    chk({tag, ".ex_store_data"}, ex_store_data, resolve(m_rs2, m_b));
  endtask

  // Advance the model by the edge about to happen, then let the DUT take it.
  task automatic cycle();
    logic [31:0] na, nb;
    if (reset || flush) begin
      m_valid = 0; m_we = 0; m_bsel = 0; m_asel = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_op = ALU_ADD;
    end else if (stall) begin
      na = resolve(m_rs1, m_a);
      nb = resolve(m_rs2, m_b);
      m_a = na; m_b = nb;
    end else begin
      m_valid = id_valid; m_we = id_reg_write & id_valid; m_rd = id_rd;
      m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_a = wb_bypass(id_rs1, id_rs1_data); m_b = wb_bypass(id_rs2, id_rs2_data);
      m_imm = id_imm; m_pc = id_pc; m_asel = id_src_a_sel; m_bsel = id_src_b_sel;
      m_op = id_operation;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic no_producers();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic load(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                      input logic [31:0] d2, input logic [1:0] asel, input logic bsel,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] op);
    reset = 0; stall = 0; flush = 0; id_valid = 1; id_reg_write = 1; id_rd = 5'd10;
    id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_src_a_sel = asel; id_src_b_sel = bsel; id_imm = imm; id_pc = pc; id_operation = op;
  endtask

  task automatic randomize_id();
    id_valid = $urandom_range(0, 3) != 0; id_reg_write = $urandom_range(0, 1);
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom);
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
    id_src_a_sel = 2'($urandom); id_src_b_sel = 1'($urandom); id_operation = 4'($urandom_range(0, 10));
  endtask

  initial begin
    no_producers();
    stall = 0; flush = 0;
    randomize_id();

    // Reset for two cycles with random decode contents
    reset = 1;
    cycle();
    randomize_id();
    cycle();
    check_all("reset");
    chk("reset.SrcA_const", SrcA, 32'd0);
    chk("reset.Operation_const", {28'd0, Operation}, 32'd0);

    // Plain load
    load(5'd3, 32'h10, 5'd4, 32'h20, 2'b00, 1'b0, 32'h0, 32'h100, ALU_ADD);
    cycle();
    check_all("plain");
    chk("plain.SrcA_const", SrcA, 32'h10);
    chk("plain.SrcB_const", SrcB, 32'h20);

    // Forwarding priority
    load(5'd5, 32'h1, 5'd4, 32'h2, 2'b00, 1'b0, 32'h0, 32'h104, ALU_SUB);
    cycle();
    exm_reg_write = 1; exm_rd = 5'd5; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'hBBBB;
    check_all("fwd_both");
    chk("fwd_both.SrcA_const", SrcA, 32'hAAAA);
    exm_reg_write = 0;
    check_all("fwd_wb");
    chk("fwd_wb.SrcA_const", SrcA, 32'hBBBB);
    no_producers();
    load(5'd0, 32'h0, 5'd4, 32'h2, 2'b00, 1'b0, 32'h0, 32'h108, ALU_ADD);
    cycle();
    exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_rd = 5'd0; wb_result = 32'hBBBB;
    check_all("fwd_x0");
    chk("fwd_x0.SrcA_const", SrcA, 32'h0);

    // Stall retention of a forwarded store value
    no_producers();
    load(5'd1, 32'h5, 5'd7, 32'hDEAD, 2'b00, 1'b0, 32'h0, 32'h10C, ALU_ADD);
    cycle();
    exm_reg_write = 1; exm_rd = 5'd7; exm_result = 32'h1234;
    check_all("stall0");
    randomize_id();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      exm_rd = 5'd9; exm_result = $urandom;
      check_all("stall");
      chk("stall.store_const", ex_store_data, 32'h1234);
    end

    // Flush together with stall
    no_producers();
    load(5'd2, 32'h9, 5'd3, 32'h4, 2'b00, 1'b0, 32'h0, 32'h110, ALU_SUB);
    cycle();
    check_all("sub");
    stall = 1; flush = 1;
    cycle();
    check_all("flush");
    chk("flush.ex_valid_const", {31'd0, ex_valid}, 32'd0);
    chk("flush.ex_reg_write_const", {31'd0, ex_reg_write}, 32'd0);

    // Capture bypass, immediate and PC selects
    load(5'd6, 32'h1, 5'd4, 32'h2, 2'b00, 1'b1, 32'hFFFFFFFC, 32'h114, ALU_ADD);
    wb_reg_write = 1; wb_rd = 5'd6; wb_result = 32'h99;
    cycle();
    no_producers();
    check_all("bypass");
    chk("bypass.SrcA_const", SrcA, 32'h99);
    chk("bypass.SrcB_const", SrcB, 32'hFFFFFFFC);
    load(5'd6, 32'h1, 5'd4, 32'h2, 2'b01, 1'b1, 32'h8, 32'h400, ALU_ADD);
    cycle();
    check_all("pcsel");
    chk("pcsel.SrcA_const", SrcA, 32'h400);
    load(5'd6, 32'h1, 5'd4, 32'h2, 2'b11, 1'b0, 32'h8, 32'h404, ALU_OR);
    cycle();
    check_all("rsvdsel");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      randomize_id();
      reset = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      cycle();
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
